// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency-discipline loop.
// Holds the sample FSM state encoding, the error width and default tuning constants.
// Also provides a magnitude helper used when classifying samples.
package freq_pkg;

  // Signed error width: a 32-bit count minus a 32-bit target never overflows 33 bits.
  localparam int ERR_W = 33;

  // Nominal gate count and mid-scale DAC code for the default 16-bit DAC.
  localparam int TARGET_CNT_DEF = 10000;
  localparam int DAC_INIT_DEF   = 32768;

  // Sample-processing FSM: one state per pipeline step after the capture edge.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_CALC    = 2'd2,
    ST_UPDATE  = 2'd3
  } state_e;

  // Magnitude of a signed error as an unsigned value of the same width.
  // The most negative reachable error is -(2^32-1), so the result always fits.
  function automatic logic [ERR_W-1:0] err_mag(input logic signed [ERR_W-1:0] e);
    logic [ERR_W-1:0] r;
    r = e[ERR_W-1] ? (~e + 1'b1) : e;
    return r;
  endfunction

endpackage

// File: rtl/dac_sat_update.sv
// Purpose: next DAC code = dac_word - (err >>> GAIN_SHIFT), clamped to the DAC range.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output simply follows the inputs.
module dac_sat_update
  import freq_pkg::*;
#(
  parameter int unsigned DAC_W      = 16,
  parameter int unsigned GAIN_SHIFT = 2
) (
  input  logic [DAC_W-1:0]        dac_word,
  input  logic signed [ERR_W-1:0] err,
  output logic [DAC_W-1:0]        dac_next
);

  // Working width leaves room for the sign and one bit of overflow on either side.
  localparam int SW = ((int'(DAC_W) > ERR_W) ? int'(DAC_W) : ERR_W) + 2;

  logic signed [ERR_W-1:0] step;
  logic signed [SW-1:0]    dac_x;
  logic signed [SW-1:0]    step_x;
  logic signed [SW-1:0]    diff;
  logic signed [SW-1:0]    dac_max;

  // Arithmetic shift rounds toward minus infinity: 3 -> 0, -3 -> -1.
  assign step    = err >>> GAIN_SHIFT;
  assign dac_x   = $signed({{(SW - int'(DAC_W)){1'b0}}, dac_word});
  assign step_x  = $signed({{(SW - ERR_W){step[ERR_W-1]}}, step});
  assign diff    = dac_x - step_x;
  assign dac_max = $signed({{(SW - int'(DAC_W)){1'b0}}, {DAC_W{1'b1}}});

  // Clamp the unbounded difference into [0, 2^DAC_W-1].
  always_comb begin
    dac_next = diff[DAC_W-1:0];
    if (diff[SW-1]) begin
      dac_next = '0;
    end else if (diff > dac_max) begin
      dac_next = '1;
    end
  end

endmodule

// File: rtl/freq_discipline.sv
// Purpose: frequency-locked loop; compares a gated cycle count with a target and steers the DAC.
// Latency: dac_load pulses on the 3rd clk edge after the valid_in rising edge is captured.
// Backpressure: none; rising edges arriving while a sample is in flight are dropped.
module freq_discipline
  import freq_pkg::*;
#(
  parameter int unsigned TARGET_CNT = TARGET_CNT_DEF,
  parameter int unsigned GAIN_SHIFT = 2,
  parameter int unsigned ERR_LIMIT  = 1000,
  parameter int unsigned LOCK_TOL   = 2,
  parameter int unsigned LOCK_N     = 4,
  parameter int unsigned DAC_W      = 16,
  parameter int unsigned DAC_INIT   = DAC_INIT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    valid_in,
  input  logic [31:0]             freq_in,
  output logic [DAC_W-1:0]        dac_word,
  output logic                    dac_load,
  output logic signed [ERR_W-1:0] err_out,
  output logic                    locked,
  output logic                    alarm
);

  // Lock counter must hold the value LOCK_N itself.
  localparam int LCW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);

  localparam logic [DAC_W-1:0] DAC_RST    = DAC_INIT[DAC_W-1:0];
  localparam logic [ERR_W-1:0] TARGET_X   = ERR_W'(TARGET_CNT);
  localparam logic [ERR_W-1:0] LIMIT_X    = ERR_W'(ERR_LIMIT);
  localparam logic [ERR_W-1:0] TOL_X      = ERR_W'(LOCK_TOL);
  localparam logic [LCW-1:0]   LOCK_FULL  = LCW'(LOCK_N);
  // Number of back-to-back outliers that raises the alarm.
  localparam logic [1:0]       OUTL_ALARM = 2'd3;

  state_e                  state;
  logic                    valid_q;
  logic                    armed;
  logic                    rise;
  logic [31:0]             freq_q;
  logic signed [ERR_W-1:0] err_c;
  logic signed [ERR_W-1:0] err_q;
  logic [ERR_W-1:0]        mag;
  logic                    outlier;
  logic                    in_tol;
  logic [DAC_W-1:0]        dac_next;
  logic [DAC_W-1:0]        dac_next_q;
  logic                    accept_q;
  logic [LCW-1:0]          lock_cnt;
  logic [1:0]              outl_cnt;

  // A level that was already high when reset released must drop once before it can count.
  assign rise = valid_in & ~valid_q & armed;

  // Zero-extend both operands so the difference is exact in 33 signed bits.
  assign err_c = $signed({1'b0, freq_q}) - $signed(TARGET_X);

  assign mag     = err_mag(err_q);
  assign outlier = (mag > LIMIT_X);
  assign in_tol  = (mag <= TOL_X);
  assign locked  = (lock_cnt == LOCK_FULL);

  dac_sat_update #(
    .DAC_W      (DAC_W),
    .GAIN_SHIFT (GAIN_SHIFT)
  ) u_sat (
    .dac_word (dac_word),
    .err      (err_q),
    .dac_next (dac_next)
  );

  // Edge detector state: registered copy of valid_in plus the seen-low qualifier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (!valid_in) begin
        armed <= 1'b1;
      end
    end
  end

  // Sample FSM: IDLE waits for an edge, then walks CAPTURE -> CALC -> UPDATE unconditionally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (!en) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (rise) state <= ST_CAPTURE;
        ST_CAPTURE: state <= ST_CALC;
        ST_CALC:    state <= ST_UPDATE;
        ST_UPDATE:  state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Datapath registers: captured count, its error, and the pending DAC code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_q     <= '0;
      err_q      <= '0;
      dac_next_q <= '0;
    end else begin
      if (en && (state == ST_IDLE) && rise) begin
        freq_q <= freq_in;
      end
      if (en && (state == ST_CAPTURE)) begin
        err_q <= err_c;
      end
      if (en && (state == ST_CALC) && !outlier) begin
        dac_next_q <= dac_next;
      end
    end
  end

  // Sample classification: outlier bookkeeping, lock tracking and the reported error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_q <= 1'b0;
      outl_cnt <= '0;
      lock_cnt <= '0;
      alarm    <= 1'b0;
      err_out  <= '0;
    end else if (!en) begin
      // Disabling the loop discards any in-flight sample and all loop status.
      accept_q <= 1'b0;
      outl_cnt <= '0;
      lock_cnt <= '0;
      alarm    <= 1'b0;
    end else if (state == ST_CALC) begin
      if (outlier) begin
        accept_q <= 1'b0;
        lock_cnt <= '0;
        if (outl_cnt != OUTL_ALARM) begin
          outl_cnt <= outl_cnt + 2'd1;
        end
        // The third consecutive outlier latches the alarm until reset or disable.
        if (outl_cnt >= (OUTL_ALARM - 2'd1)) begin
          alarm <= 1'b1;
        end
      end else begin
        accept_q <= 1'b1;
        outl_cnt <= '0;
        err_out  <= err_q;
        if (!in_tol) begin
          lock_cnt <= '0;
        end else if (lock_cnt != LOCK_FULL) begin
          lock_cnt <= lock_cnt + 1'b1;
        end
      end
    end else if (state == ST_UPDATE) begin
      accept_q <= 1'b0;
    end
  end

  // DAC register and its strobe; a clamped code still strobes even if the value is unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_word <= DAC_RST;
      dac_load <= 1'b0;
    end else begin
      dac_load <= 1'b0;
      if (en && (state == ST_UPDATE) && accept_q) begin
        dac_word <= dac_next_q;
        dac_load <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_freq_discipline.sv
// Directed bench for freq_discipline with a queue-based scoreboard.
// Stimulus pushes the expected strobe (cycle, code, error, status) per accepted sample.
// A negedge monitor pops on every dac_load; loads with nothing queued are errors.
module tb_freq_discipline;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b1;
  logic               valid_in = 1'b0;
  logic [31:0]        freq_in = 32'd0;
  logic [15:0]        dac_word;
  logic               dac_load;
  logic signed [32:0] err_out;
  logic               locked;
  logic               alarm;

  freq_discipline dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .valid_in (valid_in),
    .freq_in  (freq_in),
    .dac_word (dac_word),
    .dac_load (dac_load),
    .err_out  (err_out),
    .locked   (locked),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     at;
    int     dac;
    longint err;
    bit     lk;
    bit     al;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference loop state
  int dac_m   = 32768;
  int lock_m  = 0;
  int outl_m  = 0;
  bit alarm_m = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expectation
  always @(negedge clk) begin
    if (dac_load) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_load: dac_load=1 dac_word=%0d at cycle %0d, expected no load", dac_word, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("load_cycle", cyc, e.at);
        chk("load_dac_word", dac_word, e.dac);
        chk("load_err_out", err_out, e.err);
        chk("load_locked", locked, e.lk);
        chk("load_alarm", alarm, e.al);
      end
    end
  end

  // Issue one gate: called at a negedge; holds valid_in for 'hold' cycles then 3 low cycles.
  task automatic sample(input int v, input int hold);
    int   e;
    int   step;
    exp_t x;
    e = v - 10000;
    if (e > 1000 || e < -1000) begin
      outl_m++;
      lock_m = 0;
      if (outl_m >= 3) alarm_m = 1'b1;
    end else begin
      outl_m = 0;
      step   = e >>> 2;
      dac_m  = dac_m - step;
      if (dac_m < 0)     dac_m = 0;
      if (dac_m > 65535) dac_m = 65535;
      if (e <= 2 && e >= -2) begin
        if (lock_m < 4) lock_m++;
      end else begin
        lock_m = 0;
      end
      x.at  = cyc + 4;
      x.dac = dac_m;
      x.err = e;
      x.lk  = (lock_m == 4);
      x.al  = alarm_m;
      sb.push_back(x);
    end
    valid_in = 1'b1;
    freq_in  = v;
    repeat (hold) @(negedge clk);
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    dac_m   = 32768;
    lock_m  = 0;
    outl_m  = 0;
    alarm_m = 1'b0;
    rst_n   = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    // Values while reset is held
    chk("rst_dac_word", dac_word, 32768);
    chk("rst_dac_load", dac_load, 0);
    chk("rst_err_out", err_out, 0);
    chk("rst_locked", locked, 0);
    chk("rst_alarm", alarm, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Long pulse yields one sample
    sample(10040, 17);
    chk("t1_dac_word", dac_word, 32758);
    chk("t1_err_out", err_out, 40);

    // Negative error, then a -1 error rounding to step -1
    reset_dut();
    sample(9960, 3);
    chk("t2_dac_word", dac_word, 32778);
    sample(9999, 3);
    chk("t2b_dac_word", dac_word, 32779);
    chk("t2b_err_out", err_out, -1);

    // Lock acquisition and loss
    reset_dut();
    for (int i = 0; i < 3; i++) sample(10001, 3);
    chk("t3_locked_after_3", locked, 0);
    sample(10001, 3);
    chk("t3_locked_after_4", locked, 1);
    chk("t3_dac_word", dac_word, 32768);
    sample(10005, 3);
    chk("t3_locked_after_miss", locked, 0);
    chk("t3b_dac_word", dac_word, 32767);

    // Outliers: no strobes, alarm on the third
    sample(12000, 3);
    sample(12000, 3);
    chk("t4_alarm_after_2", alarm, 0);
    sample(12000, 3);
    chk("t4_alarm_after_3", alarm, 1);
    chk("t4_dac_word", dac_word, 32767);
    sample(10000, 3);
    chk("t4_alarm_sticky", alarm, 1);
    chk("t4b_dac_word", dac_word, 32767);
    en = 1'b0;
    @(negedge clk);
    alarm_m = 1'b0;
    lock_m  = 0;
    outl_m  = 0;
    chk("t4_alarm_en_low", alarm, 0);
    chk("t4_locked_en_low", locked, 0);
    chk("t4_dac_hold_en_low", dac_word, 32767);
    en = 1'b1;
    @(negedge clk);
    chk("t4_dac_after_en_rise", dac_word, 32767);

    // Clamp at zero, then at full scale
    for (int i = 0; i < 150; i++) sample(10900, 3);
    chk("t5_clamp_low", dac_word, 0);
    for (int i = 0; i < 300; i++) sample(9100, 3);
    chk("t5_clamp_high", dac_word, 65535);

    // Reset one cycle after capture, valid_in held across release
    valid_in = 1'b1;
    freq_in  = 10040;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    dac_m   = 32768;
    lock_m  = 0;
    outl_m  = 0;
    alarm_m = 1'b0;
    rst_n   = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_dac_after_abort", dac_word, 32768);
    chk("t6_err_after_abort", err_out, 0);
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    sample(10040, 3);
    chk("t6_dac_after_new_edge", dac_word, 32758);

    // Drain: every expected strobe must have been seen
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("pending_expectations", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
